// File: rtl/adder_arbiter_if.sv
// Request/response bundle between two ALU-side clients and the shared adder arbiter.
// master = client side (drives requests), slave = arbiter side (drives ready and responses).
interface adder_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_cin;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_cin;
    logic        rsp0_valid;
    logic [15:0] rsp0_sum;
    logic        rsp0_cout;
    logic        rsp1_valid;
    logic [15:0] rsp1_sum;
    logic        rsp1_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_sum, rsp0_cout,
        input  rsp1_valid, rsp1_sum, rsp1_cout
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_sum, rsp0_cout,
        output rsp1_valid, rsp1_sum, rsp1_cout
    );
endinterface

// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one 2-stage pipelined 16-bit adder, with tagged responses.
// Optional per-requester saturating grant counters when ADDARB_STATS_EN is defined.
module adder_16bit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [7:0] lo_sum_reg;
    logic       lo_carry_reg;
    logic [7:0] a_hi_reg;
    logic [7:0] b_hi_reg;
    logic [8:0] lo_next;
    logic [8:0] hi_sum;

    // Low byte resolves before the register cut; its carry feeds the high byte after it.
    assign lo_next = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};

    always_ff @(posedge clk) begin
        if (reset) begin
            lo_sum_reg   <= '0;
            lo_carry_reg <= 1'b0;
            a_hi_reg     <= '0;
            b_hi_reg     <= '0;
        end else begin
            lo_sum_reg   <= lo_next[7:0];
            lo_carry_reg <= lo_next[8];
            a_hi_reg     <= a[15:8];
            b_hi_reg     <= b[15:8];
        end
    end

    assign hi_sum = {1'b0, a_hi_reg} + {1'b0, b_hi_reg} + {8'd0, lo_carry_reg};
    assign sum    = {hi_sum[7:0], lo_sum_reg};
    assign cout   = hi_sum[8];
endmodule

module adder_arbiter #(
    parameter int RR    = 1,
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           hold,
    adder_arbiter_if.slave bus,
    output logic           busy
`ifdef ADDARB_STATS_EN
    ,
    output logic [15:0]    grant_cnt0,
    output logic [15:0]    grant_cnt1
`endif
);
    generate
        if (WIDTH != 16) begin : g_width_check
            $error("adder_arbiter: WIDTH must be 16 to match adder_16bit");
        end
    endgenerate

    genvar gi;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  accept;
    logic        rr_ptr_reg;
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic        sel_cin;

    logic        iss_valid_reg;
    logic        iss_id_reg;
    logic [15:0] iss_a_reg;
    logic [15:0] iss_b_reg;
    logic        iss_cin_reg;
    logic        tag_valid_reg;
    logic        tag_id_reg;
    logic [15:0] add_sum;
    logic        add_cout;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    // rr_ptr_reg = 1 means requester 1 is favoured on the next contention.
    always_comb begin
        req_ready = 2'b00;
        if (!hold && !reset) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = ((RR != 0) && rr_ptr_reg) ? 2'b10 : 2'b01;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign accept         = req_valid & req_ready;
    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];

    assign sel_a   = accept[1] ? bus.req1_a   : bus.req0_a;
    assign sel_b   = accept[1] ? bus.req1_b   : bus.req0_b;
    assign sel_cin = accept[1] ? bus.req1_cin : bus.req0_cin;

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid_reg <= 1'b0;
            iss_id_reg    <= 1'b0;
            iss_a_reg     <= '0;
            iss_b_reg     <= '0;
            iss_cin_reg   <= 1'b0;
            rr_ptr_reg    <= 1'b0;
        end else begin
            iss_valid_reg <= |accept;
            if (|accept) begin
                iss_id_reg  <= accept[1];
                iss_a_reg   <= sel_a;
                iss_b_reg   <= sel_b;
                iss_cin_reg <= sel_cin;
                rr_ptr_reg  <= accept[0];
            end
        end
    end

    adder_16bit u_adder (
        .clk   (clk),
        .reset (reset),
        .a     (iss_a_reg),
        .b     (iss_b_reg),
        .cin   (iss_cin_reg),
        .sum   (add_sum),
        .cout  (add_cout)
    );

    // Tag stage tracks the adder's internal register so id and result arrive together.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid_reg <= 1'b0;
            tag_id_reg    <= 1'b0;
        end else begin
            tag_valid_reg <= iss_valid_reg;
            tag_id_reg    <= iss_id_reg;
        end
    end

    assign busy = iss_valid_reg | tag_valid_reg;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            logic        hit;
            logic        valid_reg;
            logic [15:0] sum_reg;
            logic        cout_reg;

            assign hit = tag_valid_reg && (tag_id_reg == (gi != 0));

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    sum_reg   <= '0;
                    cout_reg  <= 1'b0;
                end else begin
                    valid_reg <= hit;
                    if (hit) begin
                        sum_reg  <= add_sum;
                        cout_reg <= add_cout;
                    end
                end
            end
        end
    endgenerate

    assign bus.rsp0_valid = g_rsp[0].valid_reg;
    assign bus.rsp0_sum   = g_rsp[0].sum_reg;
    assign bus.rsp0_cout  = g_rsp[0].cout_reg;
    assign bus.rsp1_valid = g_rsp[1].valid_reg;
    assign bus.rsp1_sum   = g_rsp[1].sum_reg;
    assign bus.rsp1_cout  = g_rsp[1].cout_reg;

`ifdef ADDARB_STATS_EN
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stats
            logic [15:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (accept[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign grant_cnt0 = g_stats[0].cnt_reg;
    assign grant_cnt1 = g_stats[1].cnt_reg;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: a round-robin instance and a fixed-priority instance.
module tb_adder_arbiter;
    logic clk;
    logic reset;
    logic hold_rr;
    logic hold_fp;
    logic busy_rr;
    logic busy_fp;
    int   checks;
    int   errors;

`ifdef ADDARB_STATS_EN
    logic [15:0] cnt0_rr, cnt1_rr, cnt0_fp, cnt1_fp;
`endif

    adder_arbiter_if bus_rr ();
    adder_arbiter_if bus_fp ();

    adder_arbiter #(.RR(1), .WIDTH(16)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .hold  (hold_rr),
        .bus   (bus_rr),
        .busy  (busy_rr)
`ifdef ADDARB_STATS_EN
        ,
        .grant_cnt0 (cnt0_rr),
        .grant_cnt1 (cnt1_rr)
`endif
    );

    adder_arbiter #(.RR(0), .WIDTH(16)) dut_fp (
        .clk   (clk),
        .reset (reset),
        .hold  (hold_fp),
        .bus   (bus_fp),
        .busy  (busy_fp)
`ifdef ADDARB_STATS_EN
        ,
        .grant_cnt0 (cnt0_fp),
        .grant_cnt1 (cnt1_fp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, got still running, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs;
        bus_rr.req0_valid = 1'b0; bus_rr.req0_a = '0; bus_rr.req0_b = '0; bus_rr.req0_cin = 1'b0;
        bus_rr.req1_valid = 1'b0; bus_rr.req1_a = '0; bus_rr.req1_b = '0; bus_rr.req1_cin = 1'b0;
        bus_fp.req0_valid = 1'b0; bus_fp.req0_a = '0; bus_fp.req0_b = '0; bus_fp.req0_cin = 1'b0;
        bus_fp.req1_valid = 1'b0; bus_fp.req1_a = '0; bus_fp.req1_b = '0; bus_fp.req1_cin = 1'b0;
        hold_rr = 1'b0;
        hold_fp = 1'b0;
    endtask

    // Leaves the bench just after a falling edge with reset low.
    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        bus_rr.req0_valid = 1'b1;
        bus_rr.req1_valid = 1'b1;
        #1;
        checks++;
        if (bus_rr.req0_ready !== 1'b0 || bus_rr.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b expected 00", bus_rr.req1_ready, bus_rr.req0_ready);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus_rr.rsp0_valid !== 1'b0 || bus_rr.rsp1_valid !== 1'b0 || busy_rr !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got rsp0=%b rsp1=%b busy=%b expected 0 0 0",
                     bus_rr.rsp0_valid, bus_rr.rsp1_valid, busy_rr);
        end
        checks++;
        if (bus_rr.rsp0_sum !== 16'h0000 || bus_rr.rsp1_sum !== 16'h0000 ||
            bus_rr.rsp0_cout !== 1'b0 || bus_rr.rsp1_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got %h/%b %h/%b expected 0000/0 0000/0",
                     bus_rr.rsp0_sum, bus_rr.rsp0_cout, bus_rr.rsp1_sum, bus_rr.rsp1_cout);
        end
        reset = 1'b0;
        clear_inputs();
        $display("reset: outputs cleared");
    endtask

    task automatic test_single_op;
        do_reset();
        bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 16'h1234; bus_rr.req0_b = 16'h0F0F; bus_rr.req0_cin = 1'b0;
        #1;
        checks++;
        if (bus_rr.req0_ready !== 1'b1 || bus_rr.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got %b%b expected 01", bus_rr.req1_ready, bus_rr.req0_ready);
        end
        @(negedge clk);
        bus_rr.req0_valid = 1'b0;
        checks++;
        if (busy_rr !== 1'b1 || bus_rr.rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_e0: got busy=%b rsp0=%b expected 1 0", busy_rr, bus_rr.rsp0_valid);
        end
        @(negedge clk);
        checks++;
        if (busy_rr !== 1'b1 || bus_rr.rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_e1: got busy=%b rsp0=%b expected 1 0", busy_rr, bus_rr.rsp0_valid);
        end
        @(negedge clk);
        checks++;
        if (bus_rr.rsp0_valid !== 1'b1 || bus_rr.rsp0_sum !== 16'h2143 ||
            bus_rr.rsp0_cout !== 1'b0 || bus_rr.rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: got v=%b sum=%h cout=%b rsp1=%b expected 1 2143 0 0",
                     bus_rr.rsp0_valid, bus_rr.rsp0_sum, bus_rr.rsp0_cout, bus_rr.rsp1_valid);
        end
        @(negedge clk);
        checks++;
        if (bus_rr.rsp0_valid !== 1'b0 || bus_rr.rsp0_sum !== 16'h2143 || busy_rr !== 1'b0) begin
            errors++;
            $display("FAIL single_after: got v=%b sum=%h busy=%b expected 0 2143 0",
                     bus_rr.rsp0_valid, bus_rr.rsp0_sum, busy_rr);
        end
        $display("single op: req0 1234+0f0f -> %h cout %b", bus_rr.rsp0_sum, bus_rr.rsp0_cout);
    endtask

    task automatic test_carry;
        bus_rr.req1_valid = 1'b1; bus_rr.req1_a = 16'h00FF; bus_rr.req1_b = 16'h0001; bus_rr.req1_cin = 1'b0;
        #1;
        checks++;
        if (bus_rr.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL carry_ready_a: got %b expected 1", bus_rr.req1_ready);
        end
        @(negedge clk);
        bus_rr.req1_a = 16'hFFFF; bus_rr.req1_b = 16'h0000; bus_rr.req1_cin = 1'b1;
        #1;
        checks++;
        if (bus_rr.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL carry_ready_b: got %b expected 1", bus_rr.req1_ready);
        end
        @(negedge clk);
        bus_rr.req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_rr.rsp1_valid !== 1'b1 || bus_rr.rsp1_sum !== 16'h0100 || bus_rr.rsp1_cout !== 1'b0) begin
            errors++;
            $display("FAIL carry_byte: got v=%b sum=%h cout=%b expected 1 0100 0",
                     bus_rr.rsp1_valid, bus_rr.rsp1_sum, bus_rr.rsp1_cout);
        end
        @(negedge clk);
        checks++;
        if (bus_rr.rsp1_valid !== 1'b1 || bus_rr.rsp1_sum !== 16'h0000 ||
            bus_rr.rsp1_cout !== 1'b1 || bus_rr.rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL carry_wrap: got v=%b sum=%h cout=%b rsp0=%b expected 1 0000 1 0",
                     bus_rr.rsp1_valid, bus_rr.rsp1_sum, bus_rr.rsp1_cout, bus_rr.rsp0_valid);
        end
        @(negedge clk);
        checks++;
        if (bus_rr.rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL carry_end: got rsp1_valid=%b expected 0", bus_rr.rsp1_valid);
        end
        $display("carry: req1 00ff+0001 and ffff+0000+1 back to back");
    endtask

    task automatic test_round_robin;
        bit exp0, exp1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            exp0 = (c >= 3) && (c <= 6) && (((c - 3) % 2) == 0);
            exp1 = (c >= 3) && (c <= 6) && (((c - 3) % 2) == 1);
            checks++;
            if (bus_rr.rsp0_valid !== exp0 || bus_rr.rsp1_valid !== exp1) begin
                errors++;
                $display("FAIL rr_rsp cycle %0d: got %b%b expected %b%b", c,
                         bus_rr.rsp1_valid, bus_rr.rsp0_valid, exp1, exp0);
            end
            if (exp0 || exp1) begin
                checks++;
                if ((exp0 && bus_rr.rsp0_sum !== 16'h0011) || (exp1 && bus_rr.rsp1_sum !== 16'h0011)) begin
                    errors++;
                    $display("FAIL rr_sum cycle %0d: got %h/%h expected 0011", c,
                             bus_rr.rsp0_sum, bus_rr.rsp1_sum);
                end
            end
            if (c < 4) begin
                bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 16'h0010; bus_rr.req0_b = 16'h0001;
                bus_rr.req1_valid = 1'b1; bus_rr.req1_a = 16'h0010; bus_rr.req1_b = 16'h0001;
                #1;
                checks++;
                if (bus_rr.req0_ready !== ((c % 2) == 0) || bus_rr.req1_ready !== ((c % 2) == 1)) begin
                    errors++;
                    $display("FAIL rr_grant cycle %0d: got %b%b expected %b%b", c,
                             bus_rr.req1_ready, bus_rr.req0_ready, (c % 2) == 1, (c % 2) == 0);
                end
                $display("rr cycle %0d: grant %0d", c, bus_rr.req1_ready ? 1 : 0);
            end else begin
                bus_rr.req0_valid = 1'b0;
                bus_rr.req1_valid = 1'b0;
            end
        end
    endtask

    task automatic test_fixed_priority;
        bit exp0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            exp0 = (c >= 3) && (c <= 5);
            checks++;
            if (bus_fp.rsp0_valid !== exp0 || bus_fp.rsp1_valid !== 1'b0) begin
                errors++;
                $display("FAIL fp_rsp cycle %0d: got %b%b expected 0%b", c,
                         bus_fp.rsp1_valid, bus_fp.rsp0_valid, exp0);
            end
            if (exp0) begin
                checks++;
                if (bus_fp.rsp0_sum !== 16'h0300) begin
                    errors++;
                    $display("FAIL fp_sum cycle %0d: got %h expected 0300", c, bus_fp.rsp0_sum);
                end
            end
            if (c < 3) begin
                bus_fp.req0_valid = 1'b1; bus_fp.req0_a = 16'h0100; bus_fp.req0_b = 16'h0200;
                bus_fp.req1_valid = 1'b1; bus_fp.req1_a = 16'h0700; bus_fp.req1_b = 16'h0700;
                #1;
                checks++;
                if (bus_fp.req0_ready !== 1'b1 || bus_fp.req1_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fp_grant cycle %0d: got %b%b expected 01", c,
                             bus_fp.req1_ready, bus_fp.req0_ready);
                end
                $display("fixed cycle %0d: grant req0", c);
            end else begin
                bus_fp.req0_valid = 1'b0;
                bus_fp.req1_valid = 1'b0;
            end
        end
    endtask

    task automatic test_hold;
        do_reset();
        bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 16'h0001; bus_rr.req0_b = 16'h0001;
        #1;
        checks++;
        if (bus_rr.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_accept: got %b expected 1", bus_rr.req0_ready);
        end
        @(negedge clk);
        bus_rr.req0_valid = 1'b0;
        bus_rr.req1_valid = 1'b1; bus_rr.req1_a = 16'h0005; bus_rr.req1_b = 16'h0005;
        hold_rr = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            checks++;
            if (bus_rr.req1_ready !== 1'b0 || bus_rr.rsp1_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_block cycle %0d: got ready1=%b rsp1=%b expected 0 0", c,
                         bus_rr.req1_ready, bus_rr.rsp1_valid);
            end
            checks++;
            if (busy_rr !== (c < 3)) begin
                errors++;
                $display("FAIL hold_busy cycle %0d: got %b expected %b", c, busy_rr, c < 3);
            end
        end
        checks++;
        if (bus_rr.rsp0_valid !== 1'b1 || bus_rr.rsp0_sum !== 16'h0002) begin
            errors++;
            $display("FAIL hold_rsp: got v=%b sum=%h expected 1 0002", bus_rr.rsp0_valid, bus_rr.rsp0_sum);
        end
        @(negedge clk);
        hold_rr = 1'b0;
        #1;
        checks++;
        if (bus_rr.req1_ready !== 1'b1 || bus_rr.rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got ready1=%b rsp0=%b expected 1 0", bus_rr.req1_ready, bus_rr.rsp0_valid);
        end
        @(negedge clk);
        bus_rr.req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus_rr.rsp1_valid !== 1'b1 || bus_rr.rsp1_sum !== 16'h000A) begin
            errors++;
            $display("FAIL hold_rsp1: got v=%b sum=%h expected 1 000a", bus_rr.rsp1_valid, bus_rr.rsp1_sum);
        end
        @(negedge clk);
        checks++;
        if (busy_rr !== 1'b0 || bus_rr.rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: got busy=%b rsp1=%b expected 0 0", busy_rr, bus_rr.rsp1_valid);
        end
        $display("hold: req0 0001+0001 -> 0002, req1 granted after release -> 000a");
    endtask

    task automatic test_reset_midflight;
        bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 16'h1111; bus_rr.req0_b = 16'h2222;
        #1;
        checks++;
        if (bus_rr.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_accept: got %b expected 1", bus_rr.req0_ready);
        end
        @(negedge clk);
        bus_rr.req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy_rr !== 1'b0 || bus_rr.rsp0_sum !== 16'h0000 || bus_rr.rsp1_sum !== 16'h0000 ||
            bus_rr.rsp0_cout !== 1'b0 || bus_rr.rsp1_cout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: got busy=%b sums=%h/%h couts=%b/%b expected 0 0000/0000 0/0",
                     busy_rr, bus_rr.rsp0_sum, bus_rr.rsp1_sum, bus_rr.rsp0_cout, bus_rr.rsp1_cout);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus_rr.rsp0_valid !== 1'b0 || bus_rr.rsp1_valid !== 1'b0 || busy_rr !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet cycle %0d: got %b%b busy=%b expected 00 0", c,
                         bus_rr.rsp1_valid, bus_rr.rsp0_valid, busy_rr);
            end
            @(negedge clk);
        end
        $display("reset mid-flight: op 1111+2222 discarded");
    endtask

`ifdef ADDARB_STATS_EN
    task automatic test_stats;
        do_reset();
        bus_rr.req0_valid = 1'b1; bus_rr.req0_a = 16'h0001; bus_rr.req0_b = 16'h0002;
        for (int c = 0; c < 3; c++) @(negedge clk);
        checks++;
        if (cnt0_rr !== 16'd3 || cnt1_rr !== 16'd0) begin
            errors++;
            $display("FAIL stats_small: got %h/%h expected 0003/0000", cnt0_rr, cnt1_rr);
        end
        for (int c = 3; c < 70000; c++) @(negedge clk);
        bus_rr.req0_valid = 1'b0;
        checks++;
        if (cnt0_rr !== 16'hFFFF || cnt1_rr !== 16'h0000 || cnt0_fp !== 16'h0000) begin
            errors++;
            $display("FAIL stats_sat: got %h/%h fp=%h expected ffff/0000 fp=0000", cnt0_rr, cnt1_rr, cnt0_fp);
        end
        hold_rr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        hold_rr = 1'b0;
        checks++;
        if (cnt0_rr !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_hold: got %h expected ffff", cnt0_rr);
        end
        do_reset();
        checks++;
        if (cnt0_rr !== 16'h0000 || cnt1_rr !== 16'h0000) begin
            errors++;
            $display("FAIL stats_reset: got %h/%h expected 0000/0000", cnt0_rr, cnt1_rr);
        end
        $display("stats: 70000 req0 accepts saturate at ffff");
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clear_inputs();
        test_reset();
        test_single_op();
        test_carry();
        test_round_robin();
        test_fixed_priority();
        test_hold();
        test_reset_midflight();
`ifdef ADDARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
